fb_write_ctrl: RTL and testbench
================================

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameter CELLS, default 4800, meaning the number of character cells per frame (80x60).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning the frame-buffer address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cpu_req, input, 1 bit: a CPU cell-write request.
REQ-006 SHALL have port cpu_addr, input, ADDR_W bits: the CPU cell address.
REQ-007 SHALL have port cpu_data, input, 8 bits: the CPU cell value.
REQ-008 SHALL have port cpu_ready, output, 1 bit: a write is accepted in any cycle where cpu_req and cpu_ready are both 1.
REQ-009 SHALL have port clear_req, input, 1 bit: a 1-cycle pulse requesting a fill of the back buffer.
REQ-010 SHALL have port clear_char, input, 8 bits: the fill value, sampled with clear_req.
REQ-011 SHALL have port swap_req, input, 1 bit: a 1-cycle pulse requesting a buffer swap.
REQ-012 SHALL have port vblank, input, 1 bit: the vertical-blank level, already synchronous to clk.
REQ-013 SHALL have port fb_wr, output, 1 bit: the frame-buffer write strobe.
REQ-014 SHALL have port fb_addr, output, ADDR_W bits: the frame-buffer write address.
REQ-015 SHALL have port fb_din, output, 8 bits: the frame-buffer write data.
REQ-016 SHALL have port fb_commit, output, 1 bit: a 1-cycle buffer-toggle pulse.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE or a swap is pending.
REQ-018 SHALL have port swap_done, output, 1 bit: a 1-cycle pulse, coincident with fb_commit.
REQ-019 SHALL have port oob_err, output, 1 bit: a 1-cycle pulse flagging an out-of-range CPU address.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, WAIT_VB and COMMIT.
REQ-021 SHALL register fb_wr, fb_addr, fb_din, fb_commit, swap_done and oob_err; cpu_ready and busy SHALL be combinational.
REQ-022 SHALL drive cpu_ready = (state==IDLE) & ~clear_req & ~swap_req & ~swap_pend.
REQ-023 SHALL, for an accepted CPU write with cpu_addr < CELLS, assert fb_wr=1 with that fb_addr and fb_din exactly one cycle after acceptance (latency 1).
REQ-024 SHALL, for an accepted CPU write with cpu_addr >= CELLS, leave fb_wr at 0 and pulse oob_err one cycle after acceptance.
REQ-025 SHALL apply priority in IDLE as clear_req > (swap_req | swap_pend) > cpu_req.
REQ-026 SHALL, on clear_req in IDLE, latch clear_char, enter CLEAR and issue fb_wr=1 for CELLS consecutive cycles with addresses 0..CELLS-1 ascending, with fb_din equal to the latched character.
REQ-027 SHALL return to IDLE in the cycle after address CELLS-1 is written, with no gap cycles and no wrap past CELLS-1.
REQ-028 SHALL ignore clear_req when state is not IDLE, with no queueing.
REQ-029 SHALL set the sticky swap_pend flag on swap_req in any state other than IDLE; swap_pend SHALL be serviced on the next IDLE cycle.
REQ-030 SHALL merge repeated swap_req pulses while swap_pend is set into one swap.
REQ-031 SHALL, when a swap starts from IDLE, enter WAIT_VB and clear swap_pend.
REQ-032 SHALL hold in WAIT_VB until vblank=1, then go to COMMIT.
REQ-033 SHALL, in COMMIT, pulse fb_commit=1 and swap_done=1 for exactly one cycle and then return to IDLE.
REQ-034 SHALL NOT issue fb_wr in WAIT_VB or COMMIT, so CPU writes cannot split across buffers.
REQ-035 SHALL, when clear_req and swap_req arrive in the same IDLE cycle, run the clear first and then the swap, giving exactly one commit.
REQ-036 SHALL, when swap_req arrives while vblank is already 1, pass through WAIT_VB in one cycle and assert fb_commit two cycles after swap_req.
REQ-037 SHALL hold fb_addr and fb_din at their last values when fb_wr=0.

Reset
REQ-038 SHALL, on rst=1, immediately set state=IDLE, swap_pend=0, fb_wr=0, fb_addr=0, fb_din=0, fb_commit=0, swap_done=0, oob_err=0 and the clear counter to 0.
REQ-039 SHALL make reset during CLEAR or WAIT_VB abandon the operation: no commit, and the partial clear is left as written.
REQ-040 SHALL give cpu_ready=1 in the first cycle after reset deasserts, provided no request is present.

Structure
REQ-041 SHALL take the state encoding, CELLS_DEFAULT=4800 and COLS=80 from the shared package fb_pkg.
REQ-042 SHALL be a single flat module with no sub-module; the clear counter is ADDR_W bits wide.

Verification
REQ-043 SHALL cover: cpu_req with addr=0x0123 and data=0x41 in IDLE -> fb_wr=1, fb_addr=0x0123, fb_din=0x41 on the next cycle, and cpu_ready stays 1.
REQ-044 SHALL cover: clear_req with clear_char=0x20 -> exactly 4800 contiguous fb_wr cycles over addresses 0..4799 with data 0x20; cpu_ready=0 throughout and 1 afterwards.
REQ-045 SHALL cover: swap_req with vblank=0 held for 100 cycles, then vblank=1 -> no fb_commit before vblank; exactly one 1-cycle fb_commit and swap_done pulse; cpu_req stalled until after COMMIT.
REQ-046 SHALL cover: clear_req and swap_req in the same cycle, plus a second swap_req during the clear -> the clear completes, then exactly one fb_commit.
REQ-047 SHALL cover: cpu_req with addr=4800 -> no fb_wr, one oob_err pulse.
REQ-048 SHALL cover: rst asserted at clear cycle 2000 -> fb_wr=0 immediately, no fb_commit, state IDLE after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the character frame-buffer write path:
// controller state encoding and the default 80x60 text geometry.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    WAIT_VB = 2'd2,
    COMMIT  = 2'd3
  } fb_state_t;

  localparam int COLS          = 80;
  localparam int ROWS          = 60;
  localparam int CELLS_DEFAULT = COLS * ROWS;

  // Linear cell index of a (row, col) position in the text frame.
  function automatic int cell_index(input int row, input int col);
    return row * COLS + col;
  endfunction

endpackage

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: arbitrates CPU cell writes, back-buffer fills
// and vblank-aligned buffer swaps onto a single registered write port.
//
// Handshake: a CPU write is taken in any cycle where cpu_req and cpu_ready are
// both 1; cpu_addr/cpu_data are sampled in that cycle and nothing else is held.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int CELLS  = CELLS_DEFAULT,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  output logic              cpu_ready,
  input  logic              clear_req,
  input  logic [7:0]        clear_char,
  input  logic              swap_req,
  input  logic              vblank,
  output logic              fb_wr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_din,
  output logic              fb_commit,
  output logic              busy,
  output logic              swap_done,
  output logic              oob_err,
  output fb_state_t         dbg_state
);

  localparam logic [ADDR_W:0]   CELLS_X   = (ADDR_W + 1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  fb_state_t         state, state_n;
  logic              swap_pend, swap_pend_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic              fb_wr_n, fb_commit_n, swap_done_n, oob_err_n;
  logic [ADDR_W-1:0] fb_addr_n;
  logic [7:0]        fb_din_n;

  assign cpu_ready = (state == IDLE) & ~clear_req & ~swap_req & ~swap_pend;
  assign busy      = (state != IDLE) | swap_pend;
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    swap_pend_n = swap_pend;
    clr_cnt_n   = clr_cnt;
    fb_wr_n     = 1'b0;
    fb_addr_n   = fb_addr;
    fb_din_n    = fb_din;
    fb_commit_n = 1'b0;
    swap_done_n = 1'b0;
    oob_err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          // A swap arriving with the clear is deferred until the fill is done.
          state_n     = CLEAR;
          swap_pend_n = swap_pend | swap_req;
          fb_wr_n     = 1'b1;
          fb_addr_n   = '0;
          fb_din_n    = clear_char;
          clr_cnt_n   = ADDR_W'(1);
        end else if (swap_req | swap_pend) begin
          state_n     = WAIT_VB;
          swap_pend_n = 1'b0;
        end else if (cpu_req) begin
          if ({1'b0, cpu_addr} < CELLS_X) begin
            fb_wr_n   = 1'b1;
            fb_addr_n = cpu_addr;
            fb_din_n  = cpu_data;
          end else begin
            oob_err_n = 1'b1;
          end
        end
      end
      CLEAR: begin
        swap_pend_n = swap_pend | swap_req;
        // fb_addr is the cell on the port this cycle; fb_din still holds the fill value.
        if (fb_addr == LAST_ADDR) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          fb_wr_n   = 1'b1;
          fb_addr_n = clr_cnt;
          clr_cnt_n = clr_cnt + ADDR_W'(1);
        end
      end
      WAIT_VB: begin
        swap_pend_n = swap_pend | swap_req;
        if (vblank) begin
          state_n     = COMMIT;
          fb_commit_n = 1'b1;
          swap_done_n = 1'b1;
        end
      end
      COMMIT: begin
        swap_pend_n = swap_pend | swap_req;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      swap_pend <= 1'b0;
      clr_cnt   <= '0;
      fb_wr     <= 1'b0;
      fb_addr   <= '0;
      fb_din    <= '0;
      fb_commit <= 1'b0;
      swap_done <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      state     <= state_n;
      swap_pend <= swap_pend_n;
      clr_cnt   <= clr_cnt_n;
      fb_wr     <= fb_wr_n;
      fb_addr   <= fb_addr_n;
      fb_din    <= fb_din_n;
      fb_commit <= fb_commit_n;
      swap_done <= swap_done_n;
      oob_err   <= oob_err_n;
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl: expected frame-buffer writes are
// queued as stimulus is driven and popped by a negedge monitor.
module tb_fb_write_ctrl;
  import fb_pkg::*;

  localparam int CELLS  = CELLS_DEFAULT;
  localparam int ADDR_W = 13;

  logic              clk, rst;
  logic              cpu_req, cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic              clear_req, swap_req, vblank;
  logic [7:0]        clear_char;
  logic              fb_wr, fb_commit, busy, swap_done, oob_err;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_din;
  fb_state_t         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [20:0] exp_q[$];
  int   commit_cnt  = 0;
  int   oob_cnt     = 0;
  logic prev_commit = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  fb_write_ctrl #(.CELLS(CELLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .clear_req(clear_req), .clear_char(clear_char),
    .swap_req(swap_req), .vblank(vblank),
    .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_din(fb_din),
    .fb_commit(fb_commit), .busy(busy), .swap_done(swap_done), .oob_err(oob_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_wr) begin
        check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [20:0] e;
          e = exp_q.pop_front();
          check("wr_addr_data", {11'd0, fb_addr, fb_din}, {11'd0, e});
        end
      end
      if (fb_commit) begin
        commit_cnt++;
        check("commit_swap_done", {31'd0, swap_done}, 32'd1);
        check("commit_one_cycle", {31'd0, prev_commit}, 32'd0);
        check("commit_after_writes", 32'(exp_q.size()), 32'd0);
      end else if (swap_done) begin
        check("swap_done_alone", {31'd0, swap_done}, 32'd0);
      end
      if (oob_err) begin
        oob_cnt++;
        check("oob_no_wr", {31'd0, fb_wr}, 32'd0);
      end
      prev_commit = fb_commit;
    end
  end

  // Driver tasks (all called and returning at a negedge)
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_drive(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cpu_req  = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    if (int'(a) < CELLS) begin
      exp_q.push_back({a, d});
      last_addr = a;
    end
    #1;
    check("cpu_ready_accept", {31'd0, cpu_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_clear(input logic [7:0] c);
    int n;
    clear_req  = 1'b1;
    clear_char = c;
    for (int i = 0; i < CELLS; i++) exp_q.push_back({ADDR_W'(i), c});
    @(negedge clk);
    clear_req  = 1'b0;
    clear_char = ~c;
    n = 0;
    while (fb_wr && n < CELLS + 10) begin
      n++;
      check("clear_ready_low", {31'd0, cpu_ready}, 32'd0);
      @(negedge clk);
    end
    check("clear_len", 32'(n), 32'(CELLS));
    check("clear_ready_after", {31'd0, cpu_ready}, 32'd1);
    check("clear_state_after", 32'(dbg_state), 32'(IDLE));
    check("clear_q_empty", 32'(exp_q.size()), 32'd0);
    last_addr = ADDR_W'(CELLS - 1);
  endtask

  initial begin
    int base, t, n, it;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    clear_req = 1'b0; clear_char = '0; swap_req = 1'b0; vblank = 1'b0;
    cyc(3);
    check("rst_fb_wr", {31'd0, fb_wr}, 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_din", 32'(fb_din), 32'd0);
    check("rst_commit", {31'd0, fb_commit}, 32'd0);
    check("rst_swap_done", {31'd0, swap_done}, 32'd0);
    check("rst_oob", {31'd0, oob_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, cpu_ready}, 32'd1);
    @(negedge clk);

    // Single CPU write, latency 1
    cpu_drive(ADDR_W'(16'h0123), 8'h41);
    cpu_req = 1'b0;
    check("wr_fb_wr", {31'd0, fb_wr}, 32'd1);
    check("wr_fb_addr", 32'(fb_addr), 32'h123);
    check("wr_fb_din", 32'(fb_din), 32'h41);
    check("wr_ready_stays", {31'd0, cpu_ready}, 32'd1);
    cyc(2);
    check("hold_addr", 32'(fb_addr), 32'h123);
    check("hold_din", 32'(fb_din), 32'h41);

    // Back-to-back random writes plus the top valid cell
    for (int i = 0; i < 24; i++)
      cpu_drive(ADDR_W'($urandom_range(0, CELLS - 1)), 8'($urandom_range(0, 255)));
    cpu_drive(ADDR_W'(CELLS - 1), 8'hA5);
    cpu_req = 1'b0;
    cyc(2);
    check("burst_q_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-range addresses
    base = oob_cnt;
    cpu_drive(ADDR_W'(CELLS), 8'h99);
    cpu_drive(ADDR_W'(8191), 8'h5A);
    cpu_req = 1'b0;
    cyc(2);
    #1;
    check("oob_pulses", 32'(oob_cnt - base), 32'd2);
    check("oob_addr_held", 32'(fb_addr), 32'(last_addr));
    @(negedge clk);

    // Full clear
    run_clear(8'h20);

    // Swap with vblank low for 100 cycles; CPU stalled meanwhile
    base = commit_cnt;
    vblank = 1'b0;
    swap_req = 1'b1;
    #1;
    check("swap_ready_low", {31'd0, cpu_ready}, 32'd0);
    @(negedge clk);
    swap_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = ADDR_W'(16'h00AB); cpu_data = 8'h77;
    for (int i = 0; i < 100; i++) begin
      check("vb_wait_ready", {31'd0, cpu_ready}, 32'd0);
      check("vb_wait_commit", {31'd0, fb_commit}, 32'd0);
      @(negedge clk);
    end
    check("vb_wait_busy", {31'd0, busy}, 32'd1);
    check("vb_wait_state", 32'(dbg_state), 32'(WAIT_VB));
    vblank = 1'b1;
    t = 0;
    while (!cpu_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("swap_ready_timeout", {31'd0, t < 20}, 32'd1);
    check("swap_commit_before_cpu", 32'(commit_cnt - base), 32'd1);
    exp_q.push_back({ADDR_W'(16'h00AB), 8'h77});
    last_addr = ADDR_W'(16'h00AB);
    @(negedge clk);
    cpu_req = 1'b0;
    cyc(2);
    check("swap_q_empty", 32'(exp_q.size()), 32'd0);

    // Swap with vblank already high: commit two cycles after request
    base = commit_cnt;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    check("fast_swap_c1", {31'd0, fb_commit}, 32'd0);
    @(negedge clk);
    check("fast_swap_c2", {31'd0, fb_commit}, 32'd1);
    check("fast_swap_done", {31'd0, swap_done}, 32'd1);
    @(negedge clk);
    check("fast_swap_c3", {31'd0, fb_commit}, 32'd0);
    #1;
    check("fast_swap_count", 32'(commit_cnt - base), 32'd1);
    @(negedge clk);

    // Clear and swap together, plus a second swap during the clear
    base = commit_cnt;
    clear_req = 1'b1; swap_req = 1'b1; clear_char = 8'h2E;
    for (int i = 0; i < CELLS; i++) exp_q.push_back({ADDR_W'(i), 8'h2E});
    @(negedge clk);
    clear_req = 1'b0; swap_req = 1'b0; clear_char = 8'h00;
    cyc(100);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    t = 0;
    while (busy && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("combo_timeout", {31'd0, t < 6000}, 32'd1);
    cyc(5);
    #1;
    check("combo_commits", 32'(commit_cnt - base), 32'd1);
    check("combo_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Reset at clear cycle 2000, with a swap pending
    base = commit_cnt;
    clear_req = 1'b1; clear_char = 8'h55;
    for (int i = 0; i < CELLS; i++) exp_q.push_back({ADDR_W'(i), 8'h55});
    @(negedge clk);
    clear_req = 1'b0;
    n = 0; it = 0;
    while (it < 4000) begin
      if (fb_wr) n++;
      if (n == 2000) break;
      swap_req = (it == 5);
      it++;
      @(negedge clk);
    end
    swap_req = 1'b0;
    check("abort_reached", 32'(n), 32'd2000);
    #1;
    rst = 1'b1;
    #1;
    check("abort_fb_wr", {31'd0, fb_wr}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_remaining", 32'(exp_q.size()), 32'(CELLS - 2000));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc(20);
    #1;
    check("abort_no_commit", 32'(commit_cnt - base), 32'd0);
    check("abort_state_after", 32'(dbg_state), 32'(IDLE));
    check("abort_ready_after", {31'd0, cpu_ready}, 32'd1);
    @(negedge clk);

    // Reset while waiting for vblank
    base = commit_cnt;
    vblank = 1'b0;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    cyc(10);
    check("wvb_state", 32'(dbg_state), 32'(WAIT_VB));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vblank = 1'b1;
    cyc(10);
    #1;
    check("wvb_no_commit", 32'(commit_cnt - base), 32'd0);
    check("wvb_idle", 32'(dbg_state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
